switch_debouncer: RTL and testbench

//  Conditions the five raw front-panel mode switches before mode decoding.
//  - Synchronises each asynchronous switch input to `clock`.
//  - Debounces each input independently.
//  - Qualifies the debounced vector as a one-hot selection.
//  - Drives the 5-bit one-hot switch vector consumed by the mode decoder.
//  - Non-one-hot states are never forwarded. The last valid selection is held.

---
 rtl/switch_debouncer_pkg.sv | 22 ++
 rtl/switch_debouncer_debounce_channel.sv | 60 ++++++
 rtl/switch_debouncer.sv | 75 +++++++
 tb/tb_switch_debouncer.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/switch_debouncer_pkg.sv
// ----------------------------------------------------------------------------
// switch_debouncer_pkg
// Shared constants and helpers for the front-panel mode-switch path.
//   NUM_SWITCHES         number of front-panel mode switches
//   DEBOUNCE_CYCLES_DEF  default debounce length (10 ms at the board clock)
//   is_onehot()          one-hot check, also used by the mode decoder
// ----------------------------------------------------------------------------
package switch_debouncer_pkg;

    localparam int NUM_SWITCHES        = 5;
    localparam int CLK_FREQ_HZ         = 27_000_000;
    localparam int DEBOUNCE_MS         = 10;
    localparam int DEBOUNCE_CYCLES_DEF = (CLK_FREQ_HZ / 1000) * DEBOUNCE_MS;

    // Vectors up to 32 bits wide; callers zero-extend narrower vectors.
    // x & (x-1) clears the lowest set bit, so the result is zero only when
    // at most one bit was set.
    function automatic logic is_onehot(input logic [31:0] vec);
        return (vec != 32'd0) && ((vec & (vec - 32'd1)) == 32'd0);
    endfunction

endpackage

// File: rtl/switch_debouncer_debounce_channel.sv
// ----------------------------------------------------------------------------
// debounce_channel
// One switch bit: 2-FF synchroniser followed by a stability counter. The
// output only takes a new level after the synchronised input has held that
// level for DEBOUNCE_CYCLES consecutive clocks.
//   clock     system clock
//   reset_n   asynchronous active-low reset
//   i_sw      normalised raw switch (1 = closed), asynchronous
//   o_stable  debounced level (1 = closed)
// ----------------------------------------------------------------------------
module debounce_channel
    import switch_debouncer_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int CNT_WIDTH       = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic clock,
    input  logic reset_n,
    input  logic i_sw,
    output logic o_stable
);

    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

    logic                 r_sync1;
    logic                 r_sync2;
    logic                 r_stable;
    logic [CNT_WIDTH-1:0] r_cnt;

    // Synchroniser: plain flop-to-flop, nothing between the stages.
    // Reset value is the open level so no phantom press follows reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_sw;
            r_sync2 <= r_sync1;
        end
    end

    // Counter only runs while the input disagrees with the accepted level;
    // any bounce back restarts it, and commit clears it, so it never wraps.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_stable <= 1'b0;
            r_cnt    <= '0;
        end else if (r_sync2 == r_stable) begin
            r_cnt    <= '0;
        end else if (r_cnt == CNT_LAST) begin
            r_stable <= r_sync2;
            r_cnt    <= '0;
        end else begin
            r_cnt    <= r_cnt + CNT_WIDTH'(1);
        end
    end

    assign o_stable = r_stable;

endmodule

// File: rtl/switch_debouncer.sv
// ----------------------------------------------------------------------------
// switch_debouncer
// Conditions the raw front-panel mode switches for the mode decoder:
// normalise polarity, synchronise and debounce each bit, then forward only
// one-hot debounced vectors. The last valid selection is held otherwise.
//   clock          system clock
//   reset_n        asynchronous active-low reset
//   switch_raw     raw bouncing switch pins (asynchronous)
//   switch_stable  debounced levels, 1 = closed
//   select_out     last accepted one-hot selection (0 until the first one)
//   select_strobe  1-cycle pulse when select_out changes
// ----------------------------------------------------------------------------
module switch_debouncer #(
    parameter int NUM_SWITCHES    = switch_debouncer_pkg::NUM_SWITCHES,
    parameter int DEBOUNCE_CYCLES = switch_debouncer_pkg::DEBOUNCE_CYCLES_DEF,
    parameter int ACTIVE_LOW      = 1
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic [NUM_SWITCHES-1:0] switch_raw,
    output logic [NUM_SWITCHES-1:0] switch_stable,
    output logic [NUM_SWITCHES-1:0] select_out,
    output logic                    select_strobe
);
    import switch_debouncer_pkg::*;

    localparam int CNT_WIDTH = $clog2(DEBOUNCE_CYCLES);

    logic [NUM_SWITCHES-1:0] w_sw_n;
    logic [NUM_SWITCHES-1:0] w_stable;
    logic                    w_take;
    logic [NUM_SWITCHES-1:0] r_select;
    logic                    r_strobe;

    // Polarity is fixed before the synchroniser so every flop downstream
    // works in "1 = closed".
    assign w_sw_n = (ACTIVE_LOW != 0) ? ~switch_raw : switch_raw;

    for (genvar g = 0; g < NUM_SWITCHES; g++) begin : g_ch
        debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_WIDTH       (CNT_WIDTH)
        ) u_ch (
            .clock    (clock),
            .reset_n  (reset_n),
            .i_sw     (w_sw_n[g]),
            .o_stable (w_stable[g])
        );
    end

    // Qualification has two states, IDLE (r_select == 0) and HELD, so the
    // selection register is the state. Channels committing together are
    // judged as one combined vector; zero or multi-bit vectors are dropped.
    always_comb begin
        w_take = 1'b0;
        if (is_onehot(32'(w_stable)) && (w_stable != r_select))
            w_take = 1'b1;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_select <= '0;
            r_strobe <= 1'b0;
        end else begin
            r_strobe <= w_take;
            if (w_take)
                r_select <= w_stable;
        end
    end

    assign switch_stable = w_stable;
    assign select_out    = r_select;
    assign select_strobe = r_strobe;

endmodule

// File: tb/tb_switch_debouncer.sv
// ----------------------------------------------------------------------------
// tb_switch_debouncer
// Directed scenarios (reset, clean press, bounce, multi-bit, all open, short
// glitch, exact-length pulse) followed by randomized switch activity. A
// reference model built from the acceptance rule ("accept a level once the
// last 8 synchronised samples all differ from the current level") is
// compared against the DUT on every falling edge.
// ----------------------------------------------------------------------------
module tb_switch_debouncer;

    localparam int N  = 5;
    localparam int DB = 8;

    logic         clock = 1'b0;
    logic         reset_n;
    logic [N-1:0] sw_raw;
    logic [N-1:0] sw_stable;
    logic [N-1:0] sel_out;
    logic         sel_strobe;

    int n_total  = 0;
    int n_bad    = 0;
    int n_strobe = 0;
    int s0;

    switch_debouncer #(
        .NUM_SWITCHES    (N),
        .DEBOUNCE_CYCLES (DB),
        .ACTIVE_LOW      (1)
    ) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .switch_raw    (sw_raw),
        .switch_stable (sw_stable),
        .select_out    (sel_out),
        .select_strobe (sel_strobe)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clock);
    endtask

    // ---------------- reference model ----------------
    // m_dl: two-clock input latency; m_win: the 7 previous delayed samples.
    logic [N-1:0] m_dl [2];
    logic [N-1:0] m_win [DB-1];
    logic [N-1:0] m_stable, m_sel;
    logic         m_strobe;
    int           m_wv;

    always @(posedge clock or negedge reset_n) begin : model
        logic [N-1:0] d, flip;
        if (!reset_n) begin
            m_dl[0]  <= '0;
            m_dl[1]  <= '0;
            for (int k = 0; k < DB-1; k++) m_win[k] <= '0;
            m_wv     <= 0;
            m_stable <= '0;
            m_sel    <= '0;
            m_strobe <= 1'b0;
        end else begin
            d    = m_dl[1];
            flip = d ^ m_stable;
            for (int k = 0; k < DB-1; k++) flip = flip & (m_win[k] ^ m_stable);
            if (m_wv < DB-1) flip = '0;
            m_dl[1] <= m_dl[0];
            m_dl[0] <= ~sw_raw;
            m_win[0] <= d;
            for (int k = 1; k < DB-1; k++) m_win[k] <= m_win[k-1];
            if (m_wv < DB-1) m_wv <= m_wv + 1;
            m_strobe <= ($countones(m_stable) == 1) && (m_stable != m_sel);
            if (($countones(m_stable) == 1) && (m_stable != m_sel)) m_sel <= m_stable;
            m_stable <= m_stable ^ flip;
        end
    end

    always @(negedge clock) begin
        chk("stable", 32'(sw_stable), 32'(m_stable));
        chk("select", 32'(sel_out), 32'(m_sel));
        chk("strobe", 32'(sel_strobe), 32'(m_strobe));
        if (sel_strobe) n_strobe <= n_strobe + 1;
    end

    // ---------------- stimulus ----------------
    initial begin
        reset_n = 1'b0;
        sw_raw  = 5'b11111;
        cyc(3);
        reset_n = 1'b1;
        cyc(3);
        chk("rst_stable", 32'(sw_stable), 32'h0);
        chk("rst_select", 32'(sel_out), 32'h0);

        // T1: select switch 0, then reset mid-run with it still closed
        sw_raw = 5'b11110;
        cyc(12);
        chk("t1_pre_sel", 32'(sel_out), 32'h01);
        @(posedge clock);
        #3 reset_n = 1'b0;
        #1;
        chk("t1_async_stable", 32'(sw_stable), 32'h0);
        chk("t1_async_select", 32'(sel_out), 32'h0);
        chk("t1_async_strobe", 32'(sel_strobe), 32'h0);
        cyc(3);
        reset_n = 1'b1;
        s0 = n_strobe;
        cyc(9);
        chk("t1_hold_stable", 32'(sw_stable), 32'h0);
        cyc(1);
        chk("t1_stable", 32'(sw_stable), 32'h01);
        chk("t1_sel_lag", 32'(sel_out), 32'h0);
        cyc(1);
        chk("t1_select", 32'(sel_out), 32'h01);
        chk("t1_strobe", 32'(sel_strobe), 32'h1);
        cyc(1);
        chk("t1_strobe_off", 32'(sel_strobe), 32'h0);
        chk("t1_nstrobe", 32'(n_strobe - s0), 32'd1);

        // T2: clean move from switch 0 to switch 1
        s0 = n_strobe;
        sw_raw = 5'b11101;
        cyc(9);
        chk("t2_hold", 32'(sw_stable), 32'h01);
        cyc(1);
        chk("t2_stable", 32'(sw_stable), 32'h02);
        cyc(1);
        chk("t2_select", 32'(sel_out), 32'h02);
        cyc(3);
        chk("t2_nstrobe", 32'(n_strobe - s0), 32'd1);

        // T3: release switch 1, bounce switch 2 every 3 clocks, then hold closed
        s0 = n_strobe;
        sw_raw = 5'b11011;
        for (int k = 0; k < 13; k++) begin
            cyc(3);
            sw_raw[2] = ~sw_raw[2];
        end
        cyc(3);
        sw_raw[2] = 1'b0;
        cyc(9);
        chk("t3_hold", 32'(sw_stable), 32'h00);
        chk("t3_sel_hold", 32'(sel_out), 32'h02);
        cyc(1);
        chk("t3_stable", 32'(sw_stable), 32'h04);
        cyc(1);
        chk("t3_select", 32'(sel_out), 32'h04);
        cyc(2);
        chk("t3_nstrobe", 32'(n_strobe - s0), 32'd1);

        // T4: two switches together, then drop one, then repeat the glitch
        s0 = n_strobe;
        sw_raw = 5'b10110;
        cyc(12);
        chk("t4_stable", 32'(sw_stable), 32'h09);
        chk("t4_sel_hold", 32'(sel_out), 32'h04);
        chk("t4_no_strobe", 32'(n_strobe - s0), 32'd0);
        sw_raw = 5'b11110;
        cyc(12);
        chk("t4_select", 32'(sel_out), 32'h01);
        chk("t4_nstrobe", 32'(n_strobe - s0), 32'd1);
        sw_raw = 5'b10110;
        cyc(12);
        sw_raw = 5'b11110;
        cyc(12);
        chk("t4_reenter_sel", 32'(sel_out), 32'h01);
        chk("t4_reenter_nstrobe", 32'(n_strobe - s0), 32'd1);

        // T5: everything open
        s0 = n_strobe;
        sw_raw = 5'b11111;
        cyc(12);
        chk("t5_stable", 32'(sw_stable), 32'h00);
        chk("t5_select", 32'(sel_out), 32'h01);
        chk("t5_nstrobe", 32'(n_strobe - s0), 32'd0);

        // T6: 7-clock glitch is rejected; an 8-clock pulse is just accepted
        s0 = n_strobe;
        sw_raw = 5'b01111;
        cyc(7);
        sw_raw = 5'b11111;
        cyc(12);
        chk("t6_stable", 32'(sw_stable), 32'h00);
        chk("t6_select", 32'(sel_out), 32'h01);
        chk("t6_nstrobe", 32'(n_strobe - s0), 32'd0);
        sw_raw = 5'b01111;
        cyc(8);
        sw_raw = 5'b11111;
        cyc(3);
        chk("t6b_stable", 32'(sw_stable), 32'h10);
        chk("t6b_select", 32'(sel_out), 32'h10);
        cyc(10);
        chk("t6b_released", 32'(sw_stable), 32'h00);
        chk("t6b_sel_hold", 32'(sel_out), 32'h10);
        chk("t6b_nstrobe", 32'(n_strobe - s0), 32'd1);

        // Randomized activity with one asynchronous reset in the middle
        for (int it = 0; it < 60; it++) begin
            if ($urandom_range(0, 1) == 0)
                sw_raw = ~(5'b00001 << $urandom_range(0, N-1));
            else
                sw_raw = 5'($urandom);
            if (it == 30) begin
                #2 reset_n = 1'b0;
                cyc(1 + $urandom_range(0, 2));
                reset_n = 1'b1;
            end
            cyc($urandom_range(1, 16));
        end
        sw_raw = 5'b11111;
        cyc(12);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
